inst_mem_resp: RTL and testbench
================================

# inst_mem_resp

Instruction-memory responder on the fetch interface: accepts word-addressed fetch requests carrying the program counter, reads a synchronous instruction store, and returns 32-bit instructions in request order. Response latency is configurable, and responses are buffered so the fetch side can stall.

It sits between the fetch stage and the instruction store. A loader write port fills the store before or during execution.

## Interface
Parameters:
- DEPTH, 1024: instruction store size in 32-bit words; power of two.
- LATENCY, 1: read pipeline stages; legal range 1..4.
- FIFO_DEPTH, 4: response buffer entries; power of two. Must be ≥ LATENCY+2 for one request per cycle.

Ports (clock and reset first):
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous and active-high.
- req_valid, in, 1: fetch request present.
- req_ready, out, 1: responder can accept a request this cycle.
- req_addr, in, `ADDR_BUS (64): word address, i.e. the PC in word units.
- resp_valid, out, 1: resp_inst and resp_err are valid.
- resp_ready, in, 1: fetch side consumes the response this cycle.
- resp_inst, out, `INST_BUS (32): fetched instruction.
- resp_err, out, 1: address was out of range; resp_inst carries NOP.
- wr_en, in, 1: loader write strobe.
- wr_addr, in, log2(DEPTH): loader word address.
- wr_data, in, `INST_BUS (32): loader data.

## Operation
- Request handshake: a request is accepted when req_valid && req_ready. Holding req_valid with req_ready low is legal; no request is lost.
- Address check:
  - In range: req_addr < DEPTH. The store is indexed with req_addr[log2(DEPTH)-1:0].
  - Out of range: req_addr ≥ DEPTH, comparing all 64 bits. The response is 32'h00000013 (NOP) with resp_err=1. No store access.
- Read pipeline:
  - Stage 1 performs the synchronous store read. Stages 2..LATENCY are plain registers carrying {valid, inst, err}.
  - The last stage pushes into the response FIFO unconditionally.
- Credit counter `outstanding` (0..FIFO_DEPTH) counts accepted but not-yet-popped requests.
  - +1 on accept, −1 on pop, unchanged when both or neither occur.
  - req_ready = !rst && (outstanding < FIFO_DEPTH), from the registered count only.
  - The FIFO can never overflow; a push into a full FIFO is an assertion failure.
- Response handshake:
  - resp_valid = FIFO not empty. The head drives resp_inst and resp_err.
  - Pop on resp_valid && resp_ready.
  - Response outputs are held stable while resp_valid=1 and resp_ready=0.
- Ordering: responses are returned strictly in acceptance order.
- Loader writes:
  - wr_en writes the store at the clock edge.
  - A same-cycle read of the same address returns the old word (read-before-write).
  - Writes are accepted even while rst=1.
- Reset:
  - Clears pipeline valids, FIFO pointers and `outstanding`.
  - Store contents are not cleared.
  - Requests in flight when rst rises are discarded, with no response.

## Timing
- Reset values: req_ready=0 while rst=1, and 1 the cycle after; resp_valid=0, resp_inst=32'h0, resp_err=0.
- Latency: a request accepted in cycle n gives resp_valid in cycle n+LATENCY+1, when the FIFO was empty.
- Throughput: with resp_ready held at 1 and FIFO_DEPTH ≥ LATENCY+2, one request is accepted every cycle indefinitely.
- Backpressure: with resp_ready=0, exactly FIFO_DEPTH requests are accepted; then req_ready=0.
  - After the first pop, req_ready returns to 1 one cycle later.
- Simultaneous accept and pop: `outstanding` is unchanged and no bubble is inserted.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Address wrap: req_addr = DEPTH−1 is in range; DEPTH and 64'hFFFF_FFFF_FFFF_FFFF are out of range.

## Structure
- The shared defines header holds `ADDR_BUS, `INST_BUS and a new `INST_NOP (32'h00000013). No block-local magic constants.
- The response buffer is one sub-module, inst_resp_fifo: parameters WIDTH=33 and DEPTH=FIFO_DEPTH; push/pop/full/empty interface.
- Pipeline registers reuse the existing parameterised DFF cell with wen=1.
- The store is a plain register array, inferable as block RAM.

## Test plan
- Reset: hold rst for 3 cycles while req_valid=1 → req_ready=0 and resp_valid=0 throughout. req_ready=1 in the first cycle after rst falls.
- Streaming: preload words 0..7 with 32'h1000_0000+i. Issue addresses 0..7 back-to-back with resp_ready=1 and LATENCY=1 → one response per cycle, in order. The first response appears 2 cycles after its accept.
- Backpressure: hold resp_ready=0 and issue 6 requests → exactly 4 accepted, then req_ready=0. Raise resp_ready → 4 responses in order, then the remaining 2.
- Out of range: with DEPTH=1024, request 1024 and 64'hFFFF_FFFF_FFFF_FFFF → resp_inst=32'h00000013 and resp_err=1 for both. A following request to address 5 returns the stored word with resp_err=0.
- Write collision: write 32'hDEAD_BEEF to address 3 in the same cycle a request for address 3 is accepted → old word returned. The next request to address 3 returns 32'hDEAD_BEEF.
- Reset mid-flight: assert rst with 3 responses outstanding → no response is ever delivered for them. `outstanding`=0 after reset, and store contents are preserved.

Source files
------------

// File: rtl/inst_mem_resp_pkg.sv
// inst_mem_resp_pkg: shared bus widths, NOP encoding and response/stage types for the instruction-memory responder
package inst_mem_resp_pkg;
    localparam int ADDR_BUS = 64;
    localparam int INST_BUS = 32;
    localparam logic [INST_BUS-1:0] INST_NOP = 32'h0000_0013;
    typedef struct packed {
        logic                err;
        logic [INST_BUS-1:0] inst;
    } resp_t;
    typedef struct packed {
        logic  vld;
        resp_t resp;
    } stage_t;
endpackage

// File: rtl/inst_resp_fifo.sv
// inst_resp_fifo: response buffer; push/din in, pop/dout out, full/empty status, dout reads 0 when empty
module inst_resp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty = wp_q == rp_q;
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout  = empty ? '0 : mem[rp_q[AW-1:0]];
    always_comb begin
        wp_d = wp_q + PW'(push);
        rp_d = rp_q + PW'(pop && !empty);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: fetch-side instruction responder; req_* in, resp_* out (in order, buffered), wr_* loader port
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_BUS-1:0]      req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INST_BUS-1:0]      resp_inst,
    output logic                     resp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [INST_BUS-1:0]      wr_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    logic [INST_BUS-1:0] store [DEPTH];
    logic [INST_BUS-1:0] rd_q;
    logic s0_vld_q, s0_vld_d, s0_err_q, s0_err_d;
    logic [OW-1:0] out_q, out_d;
    logic accept, pop, in_range, fifo_full, fifo_empty;
    stage_t s0, tail;
    resp_t head;
    assign in_range   = req_addr < ADDR_BUS'(DEPTH);
    assign req_ready  = !rst && (out_q < OW'(FIFO_DEPTH));
    assign accept     = req_valid && req_ready;
    assign resp_valid = !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign resp_inst  = head.inst;
    assign resp_err   = head.err;
    always_comb begin
        s0_vld_d = accept;
        s0_err_d = !in_range;
        out_d    = out_q + OW'(accept) - OW'(pop);
    end
    // Loader write and fetch read share one edge; the non-blocking read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) store[wr_addr] <= wr_data;
        if (accept && in_range) rd_q <= store[req_addr[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q <= 1'b0;
            out_q    <= '0;
        end else begin
            s0_vld_q <= s0_vld_d;
            out_q    <= out_d;
        end
        s0_err_q <= s0_err_d;
    end
    assign s0 = {s0_vld_q, s0_err_q, s0_err_q ? INST_NOP : rd_q};
    if (LATENCY == 1) begin : g_direct
        assign tail = s0;
    end else begin : g_pipe
        stage_t [LATENCY-2:0] pipe_q, pipe_d;
        stage_t [LATENCY-1:0] chain;
        assign chain = {pipe_q, s0};
        assign tail  = chain[LATENCY-1];
        always_comb pipe_d = chain[LATENCY-2:0];
        always_ff @(posedge clk) begin
            if (rst) pipe_q <= '0;
            else pipe_q <= pipe_d;
        end
    end
    // Credits bound outstanding requests to FIFO_DEPTH, so the unconditional push never finds it full.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(tail.vld && fifo_full));
    end
    inst_resp_fifo #(.WIDTH($bits(resp_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tail.vld),
        .din   (tail.resp),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed and random stimulus against a queue-based reference of the responder
module tb_inst_mem_resp;
    localparam int DEPTH = 1024;
    localparam int LAT   = 1;
    localparam int FD    = 4;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_err, wr_en;
    logic [63:0] req_addr;
    logic [31:0] resp_inst, wr_data;
    logic [9:0]  wr_addr;
    inst_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          due;
    } exp_t;
    exp_t        q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [63:0] req_list[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        prev_rst = 1'b0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask
    // One clock cycle: drive, check against the reference, update the reference, advance.
    task automatic step(input logic r, input logic rv, input logic [63:0] a, input logic rr,
                        input logic we, input logic [9:0] wa, input logic [31:0] wd, output logic acc);
        logic er, ev;
        exp_t e;
        rst = r; req_valid = rv; req_addr = a; resp_ready = rr;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #1;
        er = !r && (q.size() < FD);
        ev = (q.size() > 0) && (q[0].due <= cyc);
        chk("req_ready", req_ready, er);
        if (!r || prev_rst) begin
            chk("resp_valid", resp_valid, ev);
            if (ev) begin
                chk("resp_inst", resp_inst, q[0].inst);
                chk("resp_err", resp_err, q[0].err);
            end else if (r) begin
                chk("rst_inst", resp_inst, 0);
                chk("rst_err", resp_err, 0);
            end
        end
        acc = rv && er;
        if (r) q.delete();
        else begin
            if (ev && rr) void'(q.pop_front());
            if (acc) begin
                e.err  = a >= 64'(DEPTH);
                e.inst = e.err ? 32'h0000_0013 : ref_mem[a[9:0]];
                e.due  = cyc + LAT + 1;
                q.push_back(e);
            end
        end
        if (we) ref_mem[wa] = wd;
        prev_rst = r;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask
    // Issue req_list in order (holding each until accepted), resp_ready low for the first hold cycles.
    task automatic run_reqs(input int hold, input int budget);
        int k = 0;
        logic acc;
        logic [63:0] a;
        for (int c = 0; c < budget; c++) begin
            if (k >= req_list.size() && q.size() == 0) break;
            a = 64'h0;
            if (k < req_list.size()) a = req_list[k];
            step(1'b0, k < req_list.size(), a, c >= hold, 1'b0, 10'h0, 32'h0, acc);
            if (acc) k++;
        end
        chk("drain_done", (k == req_list.size()) && (q.size() == 0), 1);
        req_list.delete();
    endtask
    initial begin
        logic acc;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 10'h0, 32'h0, acc);
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 10'(i), (i < 8) ? 32'h1000_0000 + i : $urandom, acc);
        for (int i = 0; i < 8; i++) req_list.push_back(64'(i));
        run_reqs(0, 40);
        for (int i = 0; i < 6; i++) req_list.push_back(64'(10 + i));
        run_reqs(8, 60);
        req_list.push_back(64'd1024);
        req_list.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        req_list.push_back(64'd5);
        run_reqs(0, 30);
        step(1'b0, 1'b1, 64'd3, 1'b1, 1'b1, 10'd3, 32'hDEAD_BEEF, acc);
        req_list.push_back(64'd3);
        run_reqs(0, 20);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'(i + 1), 1'b0, 1'b0, 10'h0, 32'h0, acc);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 10'h0, 32'h0, acc);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 10'h0, 32'h0, acc);
        req_list.push_back(64'd3);
        run_reqs(0, 20);
        for (int i = 0; i < 5; i++) req_list.push_back(64'(20 + i));
        run_reqs(10, 60);
        for (int i = 0; i < 600; i++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, DEPTH + 20));
            step($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, a, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, 10'($urandom), $urandom, acc);
        end
        run_reqs(0, 40);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
